scoreboard_alu: RTL
===================

# scoreboard_alu

Self-checking scoreboard that sits downstream of the ALU stimulus driver and the ALU DUT in the bench. It samples the driven operands and opcode, computes the golden ALU result, and aligns it with the DUT output through a configurable latency pipe. It then compares, counts checks and errors, and reports pass/fail after a programmed number of checks.

## Interface
- LATENCY, 0, DUT delay in clock edges from operand sample to valid result; 0 = combinational ALU
- NUM_CHECKS, 1000, number of compared samples before DONE
- CNT_W, 32, counter width
- i_clk  in  1  bench clock
- i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- i_operand_a  in  32  operand A as driven to DUT
- i_operand_b  in  32  operand B as driven to DUT
- i_alu_op  in  ALUSel_e  opcode as driven to DUT
- i_alu_data  in  32  DUT result
- i_en  in  1  sample enable; low inserts a bubble
- o_check_cnt  out  CNT_W  compared samples
- o_err_cnt  out  CNT_W  mismatches
- o_err_pulse  out  1  one-cycle flag on mismatch
- o_exp_data  out  32  expected value of the latest compare
- o_done  out  1  NUM_CHECKS reached
- o_pass  out  1  o_done && o_err_cnt == 0

## Operation
- Golden model, with sh = b[4:0]:
  - ADD: a+b mod 2^32; SUB: a−b mod 2^32
  - XOR, OR, AND: bitwise
  - SLL: a<<sh; SRL: logical a>>sh; SRA: arithmetic signed a>>>sh
  - SLT: signed a<b → 32'd1, else 0; SLTU: unsigned compare, same encoding
  - Opcode outside these ten: entry marked invalid; no compare, no count
- States:
  - WARMUP: entered on reset. The first enabled edge is discarded because the driver outputs are undefined before their first update. → CHECK.
  - CHECK: every edge shifts the delay pipe of depth LATENCY. The new entry is {valid=i_en, exp}. The entry emerging now, or the current entry when LATENCY=0, is compared if valid.
    - o_check_cnt +1 per compare.
    - Mismatch uses 4-state inequality, so X/Z on i_alu_data counts as an error: o_err_cnt +1 and o_err_pulse.
    - When o_check_cnt reaches NUM_CHECKS → DONE.
  - DONE: counters frozen, no further compares, o_done=1. Exit only by reset.
- Counters saturate at all-ones.
- i_en low in CHECK: bubble enters the pipe; the pipe never stalls because the DUT free-runs.

## Timing
- Reset values: all counters 0, o_err_pulse 0, o_exp_data 0, o_done 0, o_pass 0, pipe valids 0, state WARMUP.
- Reset asserted mid-CHECK or mid-DONE: immediate asynchronous clear to the reset values above.
- Compare at edge k uses i_alu_data at edge k against expected from edge k−LATENCY.
- Outputs are registered and visible one cycle after the compare edge.
- o_err_pulse is high exactly one cycle per mismatch.
- The final compare and the DONE transition happen on the same edge; o_done and o_pass rise with the last count update.
- Pipe entries in flight at DONE are dropped.

## Configuration
- SCOREBOARD_ALU_LOG_EN defined:
  - $display per mismatch: time, opcode name, a, b, expected, actual
  - One summary line on DONE entry: checks, errors, PASS/FAIL
- Undefined: silent. Counters, flags and timing are identical in both builds.

## Structure
- singlecycle_pkg (existing) supplies ALUSel_e.
- Add SbState_e {SB_WARMUP, SB_CHECK, SB_DONE} to the bench package.
- Sub-module alu_ref_model: combinational golden model with inputs a, b, op and outputs exp, legal. The scoreboard holds the FSM, pipe and counters.

## Test plan
- Reset held, then released, one enabled edge → all outputs 0, o_check_cnt stays 0 (warmup).
- ADD a=32'hFFFF_FFFF b=1, DUT returns 0 → o_check_cnt=1, o_err_cnt=0 (wrap).
- SRA a=32'h8000_0000 b=32'h24, DUT returns 32'h0800_0000 → o_exp_data=32'hF800_0000, o_err_cnt=1, o_err_pulse high one cycle.
- SLT then SLTU, each with a=32'hFFFF_FFFF b=0, DUT returns 1 then 0 → both match, o_err_cnt unchanged.
- LATENCY=2, DUT result delayed two edges, i_en low one cycle mid-stream → that slot not compared, 0 errors, o_check_cnt = enabled edges.
- NUM_CHECKS=4, all correct → o_done=o_pass=1 after the 4th compare. A later bad result is ignored. Reset asserted in DONE → everything returns to 0.

Source files
------------

// File: rtl/scoreboard_alu_pkg.sv
// Shared types for the ALU scoreboard: opcode encoding of the single-cycle ALU
// and the scoreboard FSM states.
package scoreboard_alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } ALUSel_e;

  typedef enum logic [1:0] {
    SB_WARMUP,
    SB_CHECK,
    SB_DONE
  } SbState_e;

  localparam int DATA_W = 32;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden ALU: expected result plus a flag saying the opcode
// is one of the ten defined operations.
module alu_ref_model
  import scoreboard_alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  ALUSel_e           op,
  output logic [DATA_W-1:0] exp,
  output logic              legal
);

  logic [4:0] sh;
  assign sh = b[4:0];

  always_comb begin
    exp   = '0;
    legal = 1'b1;
    case (op)
      ALU_ADD:  exp = a + b;
      ALU_SUB:  exp = a - b;
      ALU_SLL:  exp = a << sh;
      ALU_SLT:  exp = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: exp = {31'd0, a < b};
      ALU_XOR:  exp = a ^ b;
      ALU_SRL:  exp = a >> sh;
      ALU_SRA:  exp = $unsigned($signed(a) >>> sh);
      ALU_OR:   exp = a | b;
      ALU_AND:  exp = a & b;
      default:  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/scoreboard_alu.sv
// ALU scoreboard: golden result delayed LATENCY edges, compared with the DUT,
// counted until NUM_CHECKS. Define SCOREBOARD_ALU_LOG_EN for mismatch/summary logging.
module scoreboard_alu
  import scoreboard_alu_pkg::*;
#(
  parameter int LATENCY    = 0,
  parameter int NUM_CHECKS = 1000,
  parameter int CNT_W      = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_operand_a,
  input  logic [DATA_W-1:0] i_operand_b,
  input  ALUSel_e           i_alu_op,
  input  logic [DATA_W-1:0] i_alu_data,
  input  logic              i_en,
  output logic [CNT_W-1:0]  o_check_cnt,
  output logic [CNT_W-1:0]  o_err_cnt,
  output logic              o_err_pulse,
  output logic [DATA_W-1:0] o_exp_data,
  output logic              o_done,
  output logic              o_pass,
  output SbState_e          o_state
);

  localparam logic [CNT_W-1:0] NUM_CHECKS_C = CNT_W'(NUM_CHECKS);

  SbState_e          state;
  logic [DATA_W-1:0] ref_exp;
  logic              ref_legal;
  logic              new_valid;
  logic              cmp_valid;
  logic [DATA_W-1:0] cmp_exp;
  logic              mismatch;
  logic [CNT_W-1:0]  chk_next;
  logic [CNT_W-1:0]  err_next;
  logic [CNT_W-1:0]  err_after;

  assign o_state = state;

  alu_ref_model u_ref (
    .a     (i_operand_a),
    .b     (i_operand_b),
    .op    (i_alu_op),
    .exp   (ref_exp),
    .legal (ref_legal)
  );

  // An entry is valid when sampled in CHECK with i_en high and a legal opcode;
  // the pipe shifts every edge regardless, since the DUT never stalls.
  assign new_valid = (state == SB_CHECK) && i_en && ref_legal;

  if (LATENCY == 0) begin : g_comb
    assign cmp_valid = new_valid;
    assign cmp_exp   = ref_exp;
  end else begin : g_pipe
    logic [LATENCY-1:0] vld_q;
    logic [DATA_W-1:0]  exp_q [LATENCY];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        vld_q <= '0;
        for (int i = 0; i < LATENCY; i++) exp_q[i] <= '0;
      end else begin
        vld_q[0] <= new_valid;
        exp_q[0] <= ref_exp;
        for (int i = 1; i < LATENCY; i++) begin
          vld_q[i] <= vld_q[i-1];
          exp_q[i] <= exp_q[i-1];
        end
      end
    end

    assign cmp_valid = vld_q[LATENCY-1];
    assign cmp_exp   = exp_q[LATENCY-1];
  end

  // 4-state inequality so an X/Z DUT result is reported as an error.
  assign mismatch  = (cmp_exp !== i_alu_data);
  assign chk_next  = (o_check_cnt == '1) ? o_check_cnt : o_check_cnt + CNT_W'(1);
  assign err_next  = (o_err_cnt == '1) ? o_err_cnt : o_err_cnt + CNT_W'(1);
  assign err_after = mismatch ? err_next : o_err_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= SB_WARMUP;
      o_check_cnt <= '0;
      o_err_cnt   <= '0;
      o_err_pulse <= 1'b0;
      o_exp_data  <= '0;
      o_done      <= 1'b0;
      o_pass      <= 1'b0;
    end else begin
      o_err_pulse <= 1'b0;
      case (state)
        SB_WARMUP: begin
          if (i_en) state <= SB_CHECK;
        end
        SB_CHECK: begin
          if (cmp_valid) begin
            o_check_cnt <= chk_next;
            o_exp_data  <= cmp_exp;
            if (mismatch) begin
              o_err_cnt   <= err_next;
              o_err_pulse <= 1'b1;
            end
            if (chk_next == NUM_CHECKS_C) begin
              state  <= SB_DONE;
              o_done <= 1'b1;
              o_pass <= (err_after == '0);
            end
          end
        end
        SB_DONE: begin
          state <= SB_DONE;
        end
        default: state <= SB_WARMUP;
      endcase
    end
  end

`ifdef SCOREBOARD_ALU_LOG_EN
  logic [DATA_W-1:0] log_a;
  logic [DATA_W-1:0] log_b;
  ALUSel_e           log_op;

  if (LATENCY == 0) begin : g_log_comb
    assign log_a  = i_operand_a;
    assign log_b  = i_operand_b;
    assign log_op = i_alu_op;
  end else begin : g_log_pipe
    logic [DATA_W-1:0] a_q  [LATENCY];
    logic [DATA_W-1:0] b_q  [LATENCY];
    ALUSel_e           op_q [LATENCY];

    always_ff @(posedge i_clk) begin
      a_q[0]  <= i_operand_a;
      b_q[0]  <= i_operand_b;
      op_q[0] <= i_alu_op;
      for (int i = 1; i < LATENCY; i++) begin
        a_q[i]  <= a_q[i-1];
        b_q[i]  <= b_q[i-1];
        op_q[i] <= op_q[i-1];
      end
    end

    assign log_a  = a_q[LATENCY-1];
    assign log_b  = b_q[LATENCY-1];
    assign log_op = op_q[LATENCY-1];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n && state == SB_CHECK && cmp_valid) begin
      if (mismatch)
        $display("[%0t] scoreboard_alu mismatch op=%s a=%h b=%h exp=%h act=%h",
                 $time, log_op.name(), log_a, log_b, cmp_exp, i_alu_data);
      if (chk_next == NUM_CHECKS_C)
        $display("scoreboard_alu done: checks=%0d errors=%0d %s",
                 chk_next, err_after, (err_after == '0) ? "PASS" : "FAIL");
    end
  end
`else
  // Silent build: counters and flags only.
`endif

endmodule
